// File: rtl/conv_pool_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_pool_stage_if
// Description : Pixel-in / pooled-result-out handshake bundle for
//               conv_pool_stage.
// Revision    : 1.0  initial release
// ============================================================================
interface conv_pool_stage_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic [C*N-1:0] in_data;
    logic [N-1:0]   in_bias;
    logic           in_valid;
    logic           in_ready;
    logic           pool_mode;
    logic [N-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           end_op;

    modport master (
        output in_data, in_bias, in_valid, pool_mode, out_ready,
        input  in_ready, out_data, out_valid, end_op
    );

    modport slave (
        input  in_data, in_bias, in_valid, pool_mode, out_ready,
        output in_ready, out_data, out_valid, end_op
    );
endinterface
`default_nettype wire

// File: rtl/conv_pool_stage.sv
`default_nettype none
// ============================================================================
// Module      : conv_pool_stage
// Description : Channel sum + bias, saturate, ReLU, then PxP max/avg pooling
//               over an MxM raster-ordered frame. CONV_POOL_AVG_EN compiles in
//               the average-pooling path (otherwise max pooling only).
// Revision    : 1.0  initial release
// ============================================================================
module conv_pool_stage #(
    parameter int N = 16,
    parameter int Q = 12,
    parameter int C = 4,
    parameter int M = 8,
    parameter int P = 2
) (
    input  wire logic         clk,
    input  wire logic         global_rst_n,
    conv_pool_stage_if.slave  bus
);

    localparam int c_LP  = $clog2(P);
    localparam int c_CW  = $clog2(M);
    localparam int c_SW  = N + $clog2(C + 1);
    localparam int c_ENT = M / P;
    localparam int c_IW  = (c_ENT > 1) ? $clog2(c_ENT) : 1;
`ifdef CONV_POOL_AVG_EN
    localparam int c_BW  = N + 2 * c_LP;
`else
    localparam int c_BW  = N;
`endif

    localparam logic [c_CW-1:0]        c_LAST_POS = c_CW'(M - 1);
    localparam logic signed [c_SW-1:0] c_SAT_MAX  = c_SW'({1'b0, {(N-1){1'b1}}});

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    generate
        if (C < 1 || P < 2 || (P & (P - 1)) != 0 || (M % P) != 0 || Q >= N) begin : g_param_error
            $error("conv_pool_stage: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake and frame position
    // ------------------------------------------------------------------------
    logic            r_out_valid;
    logic [N-1:0]    r_out_data;
    logic            r_out_end;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_out_xfer;
    logic [c_CW-1:0] r_row;
    logic [c_CW-1:0] r_col;
    logic            w_first_px;
    logic            w_last_px;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    // A pending, un-taken result stalls the whole pipeline.
    assign w_in_ready = !(r_out_valid && !bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;
    assign w_first_px = (r_row == '0) && (r_col == '0);
    assign w_last_px  = (r_row == c_LAST_POS) && (r_col == c_LAST_POS);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.end_op    = r_out_end;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == c_LAST_POS) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST_POS) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_RUN;
            c_RUN:   if (w_accept && w_last_px) w_state_nxt = c_DRAIN;
            c_DRAIN: begin
                if (w_accept)
                    w_state_nxt = c_RUN;
                else if (w_out_xfer && r_out_end)
                    w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)
            r_state <= c_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------------
    // Pooling mode, latched on pixel 0 and held for the frame
    // ------------------------------------------------------------------------
`ifdef CONV_POOL_AVG_EN
    logic r_frame_mode;
    logic w_px_mode;

    assign w_px_mode = w_first_px ? bus.pool_mode : r_frame_mode;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)
            r_frame_mode <= 1'b0;
        else if (w_accept && w_first_px)
            r_frame_mode <= bus.pool_mode;
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = bus.pool_mode;
`endif

    // ------------------------------------------------------------------------
    // Stage 1: channel sum + bias, saturate, ReLU
    // ------------------------------------------------------------------------
    logic signed [c_SW-1:0] w_sum;
    logic [N-1:0]           w_act;

    always_comb begin
        w_sum = c_SW'($signed(bus.in_bias));
        for (int i = 0; i < C; i++) begin
            w_sum = w_sum + c_SW'($signed(bus.in_data[i*N +: N]));
        end
        if (w_sum[c_SW-1])
            w_act = '0;
        else if (w_sum > c_SAT_MAX)
            w_act = {1'b0, {(N-1){1'b1}}};
        else
            w_act = w_sum[N-1:0];
    end

    logic            r_s1_valid;
    logic [N-1:0]    r_s1_data;
    logic [c_LP-1:0] r_s1_row_lo;
    logic [c_CW-1:0] r_s1_col;
    logic            r_s1_last;
`ifdef CONV_POOL_AVG_EN
    logic            r_s1_mode;
`endif

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_row_lo <= '0;
            r_s1_col    <= '0;
            r_s1_last   <= 1'b0;
`ifdef CONV_POOL_AVG_EN
            r_s1_mode   <= 1'b0;
`endif
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_data   <= w_act;
                r_s1_row_lo <= r_row[c_LP-1:0];
                r_s1_col    <= r_col;
                r_s1_last   <= w_last_px;
`ifdef CONV_POOL_AVG_EN
                r_s1_mode   <= w_px_mode;
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: per-window row buffer and output register
    // ------------------------------------------------------------------------
    logic [c_BW-1:0] r_buf [c_ENT];
    logic [c_IW-1:0] w_idx;
    logic            w_win_first;
    logic            w_win_last;
    logic            w_s2_go;
    logic [c_BW-1:0] w_cur;
    logic [c_BW-1:0] w_ext;
    logic [c_BW-1:0] w_upd;
    logic [N-1:0]    w_result;

    assign w_idx       = c_IW'(r_s1_col >> c_LP);
    assign w_win_first = (r_s1_row_lo == '0) && (r_s1_col[c_LP-1:0] == '0);
    assign w_win_last  = (&r_s1_row_lo) && (&r_s1_col[c_LP-1:0]);
    assign w_s2_go     = w_in_ready && r_s1_valid;

    // Activations are non-negative after ReLU, so unsigned max/sum is exact.
    always_comb begin
        w_cur = r_buf[w_idx];
        w_ext = c_BW'(r_s1_data);
        w_upd = (w_ext > w_cur) ? w_ext : w_cur;
`ifdef CONV_POOL_AVG_EN
        if (r_s1_mode)
            w_upd = w_cur + w_ext;
`endif
        if (w_win_first)
            w_upd = w_ext;
`ifdef CONV_POOL_AVG_EN
        w_result = r_s1_mode ? N'(w_upd >> (2 * c_LP)) : N'(w_upd);
`else
        w_result = N'(w_upd);
`endif
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int i = 0; i < c_ENT; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_s2_go) begin
            r_buf[w_idx] <= w_upd;
        end
    end

    // A new result may load in the same cycle the previous one is taken.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_end   <= 1'b0;
        end else if (w_s2_go && w_win_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_end   <= r_s1_last;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_end   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/conv_pool_stage.md
CONV_POOL_STAGE -- requirements
Module: conv_pool_stage

Interface
REQ-001 Parameter N, default 16, fixed-point word width (signed, two's complement).
REQ-002 Parameter Q, default 12, fractional bits; no rescaling inside block, carried for consistency only.
REQ-003 Parameter C, default 4, input channels summed per pixel (C >= 1).
REQ-004 Parameter M, default 8, conv output map width = height; M divisible by P.
REQ-005 Parameter P, default 2, pooling window and stride; power of two, >= 2.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 global_rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_data  input  C*N  one conv-output pixel for all channels; channel c at bits [c*N+N-1 : c*N].
REQ-009 in_bias  input  N  bias added to channel sum; stable for a frame.
REQ-010 in_valid / in_ready  input / output  1 each  pixel handshake; transfer when both high.
REQ-011 pool_mode  input  1  0 = max pool, 1 = average pool (see Configuration).
REQ-012 out_data  output  N  pooled result.
REQ-013 out_valid / out_ready  output / input  1 each  result handshake; transfer when both high.
REQ-014 end_op  output  1  high with the last pooled result of a frame while out_valid high.

Function
REQ-015 Pixels arrive in raster order, M*M per frame; block tracks row/col counters, wrapping to 0,0 after pixel M*M-1.
REQ-016 Stage 1: sum all C channels plus in_bias in N+clog2(C+1) bits; saturate to signed N-bit range; ReLU (negative -> 0); register result.
REQ-017 Stage 2: row buffer of M/P entries holds per-window running max (max mode) or running sum in N+2*log2(P) bits (avg mode); first pixel of a window loads, later pixels update.
REQ-018 On the window's last pixel (row%P==P-1, col%P==P-1) result loads the output register: max, or sum >> 2*log2(P) (truncation) in avg mode.
REQ-019 Latency: out_valid rises on the 2nd rising edge after acceptance of the window's final pixel.
REQ-020 out_data/out_valid/end_op hold stable while out_valid && !out_ready.
REQ-021 in_ready = !(out_valid && !out_ready); when low, stage-1 and stage-2 registers freeze (full-pipeline stall, no data loss or duplication).
REQ-022 Output register cleared (out_valid low) on transfer unless a new result loads the same cycle; back-to-back results allowed.
REQ-023 FSM states IDLE (no frame in progress), RUN (frame in progress), DRAIN (last pixel accepted, results pending); IDLE->RUN on first accepted pixel; RUN->DRAIN on pixel M*M-1; DRAIN->IDLE on transfer with end_op; DRAIN->RUN if a new frame's first pixel is accepted before that transfer.
REQ-024 pool_mode sampled on first pixel of each frame and held for the frame; changes mid-frame ignored.
REQ-025 Saturation at +/-: sum above 2^(N-1)-1 -> 0x7FFF (N=16), below -2^(N-1) -> 0 after ReLU.

Reset
REQ-026 Asserting global_rst_n low immediately clears counters, FSM to IDLE, row buffer, stage registers; out_data=0, out_valid=0, end_op=0; in_ready=1.
REQ-027 Reset mid-frame discards partial windows; next accepted pixel after deassertion is pixel 0,0 of a new frame.

Configuration
REQ-028 Macro CONV_POOL_AVG_EN: defined -> average pooling path and wide row buffer compiled in, pool_mode honoured.
REQ-029 Undefined -> max pooling only, row buffer N bits wide, pool_mode ignored; behaviour identical to pool_mode=0.

Verification
REQ-030 C=4, M=4, P=2, max mode, channels {0x0400,0x0400,0,0}, bias 0, ramp pattern -> 4 outputs each equal to window max, end_op with 4th only.
REQ-031 Avg mode (macro defined), window values 0x1000,0x2000,0x3000,0x0000 -> out_data 0x1800.
REQ-032 All channels 0x7000, bias 0x7000 -> saturated 0x7FFF; all channels 0x9000 -> 0x0000 (ReLU).
REQ-033 out_ready held low 5 cycles with a result pending -> in_ready low, out_data stable, no pixel lost; full frame output matches golden model.
REQ-034 global_rst_n low after 6 pixels of a frame, then full frame -> exactly M*M/(P*P) outputs, correct values, single end_op.
REQ-035 Two frames back-to-back, pool_mode toggled mid-frame 1 -> frame 1 uses mode sampled at its pixel 0, frame 2 uses new mode, FSM never enters IDLE between frames.
